instruction_fetch_sequencer: RTL

//   Sequences the 9-bit instruction ROM for the core.
//   - Owns the program counter (PC) and drives the ROM address.
//   - Latches the ROM output into an instruction register and offers it to the execute stage with a valid/ready handshake.
//   - Applies jump/branch redirects reported by execute.
//   - Stops on the halt instruction or when the PC runs past the program.

---
 rtl/instruction_fetch_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer for the 9-bit instruction ROM: PC, instruction register, valid/ready issue, redirects, halt/fault.
// Optional retired-instruction counter built only when SEQ_RETIRE_COUNT_EN is defined.
module instruction_fetch_sequencer #(
  parameter int                 ADDR_W      = 8,
  parameter int                 INSTR_W     = 9,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [ADDR_W-1:0]  PROG_LAST   = ADDR_W'(17),
  parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(9'b011100010)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        retired_count
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] instr_next;
  logic               fault_next;
  logic               handshake;

  // Status outputs decode straight from state so reset drops them without waiting for a clock.
  assign rom_addr    = pc;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign handshake   = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
      fault <= fault_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    fault_next = fault;
    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (pc > PROG_LAST) begin
          fault_next = 1'b1;
          state_next = HALT;
        end else begin
          instr_next = rom_instr;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (instr == HALT_OPCODE) begin
            state_next = HALT;
          end else begin
            // Jump has priority over branch; both wrap modulo 2^ADDR_W.
            if (jump_en)           pc_next = jump_target;
            else if (branch_taken) pc_next = pc + branch_offset;
            else                   pc_next = pc + ADDR_W'(1);
            state_next = FETCH;
          end
        end
      end
      HALT: begin
        if (start) begin
          fault_next = 1'b0;
          pc_next    = RESET_PC;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] count;
  logic        clear_count;

  assign clear_count = start & ((state == IDLE) | (state == HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear_count) begin
      count <= '0;
    end else if (handshake && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign retired_count = count;
`else
  assign retired_count = 16'h0000;
`endif

endmodule
